result_display_ctrl: RTL and testbench

Downstream consumer of seizure_detection_system outputs on the FPGA demo board. Captures each classification result on the rising edge of result_valid and drives the result LEDs for a fixed hold time. Steady seizure LED means high confidence; blinking seizure LED means low confidence. Also keeps saturating seizure/total classification counters and the last confidence value for debug readout.

---
 rtl/seizure_display_pkg.sv | 24 ++
 rtl/display_timer.sv | 37 +++
 rtl/result_display_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_result_display_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seizure_display_pkg.sv
// seizure_display_pkg
// Shared types and constants for the result display controller:
//   state_t            - display state (IDLE, HOLD)
//   STATUS_PROCESSING  - classifier system_status code meaning "processing"
//   timer_width()      - counter width needed for a timer loaded with cycles-1
package seizure_display_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [1:0] STATUS_PROCESSING = 2'b01;

    // A timer that counts from cycles-1 down to 0 needs $clog2(cycles) bits,
    // but never fewer than one bit.
    function automatic int timer_width(input int cycles);
        if (cycles <= 2) begin
            return 1;
        end
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/display_timer.sv
// display_timer
// Loadable down-counter with a zero flag. Load has priority over enable.
// The counter stops at zero rather than wrapping.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (count -> 0)
//   load        - load load_value on this edge
//   load_value  - value loaded when load is high
//   enable      - decrement by one when not loading and not already zero
//   zero        - high while the count is zero
module display_timer
    import seizure_display_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/result_display_ctrl.sv
// result_display_ctrl
// Captures a classifier result on each rising edge of result_valid and shows
// it on the result LEDs for HOLD_CYCLES cycles. A seizure result with high
// confidence lights seizure_led steadily; with low confidence it blinks with
// a half-period of BLINK_HALF cycles. Saturating statistics counters and the
// last captured confidence are kept for debug readout.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   result_valid      - classifier result valid (level, edge-detected here)
//   seizure_detected  - classifier decision, sampled on capture
//   confidence        - classifier confidence, sampled on capture
//   system_status     - classifier status, mirrored onto processing_led
//   clear_stats       - clears the statistics counters
//   seizure_led       - seizure result shown (steady or blinking)
//   non_seizure_led   - non-seizure result shown
//   processing_led    - registered (system_status == PROCESSING)
//   display_busy      - a result is currently held
//   seizure_count     - captured seizure results, saturating
//   total_count       - captured results, saturating
//   last_confidence   - confidence of the most recent capture
module result_display_ctrl
    import seizure_display_pkg::*;
#(
    parameter int          HOLD_CYCLES = 50_000_000,
    parameter int          BLINK_HALF  = 6_250_000,
    parameter logic [15:0] CONF_THRESH = 16'h8000,
    parameter int          COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   result_valid,
    input  logic                   seizure_detected,
    input  logic [15:0]            confidence,
    input  logic [1:0]             system_status,
    input  logic                   clear_stats,
    output logic                   seizure_led,
    output logic                   non_seizure_led,
    output logic                   processing_led,
    output logic                   display_busy,
    output logic [COUNT_WIDTH-1:0] seizure_count,
    output logic [COUNT_WIDTH-1:0] total_count,
    output logic [15:0]            last_confidence
);

    localparam int HOLD_W  = timer_width(HOLD_CYCLES);
    localparam int BLINK_W = timer_width(BLINK_HALF);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_HALF - 1);

    state_t      state;
    state_t      state_next;
    logic        valid_prev;
    logic        capture;
    logic        decision;
    logic        decision_next;
    logic [15:0] conf_latched;
    logic [15:0] conf_next;
    logic        phase;
    logic        phase_next;
    logic        hold_zero;
    logic        blink_zero;
    logic        blink_reload;
    logic        in_hold;
    logic        seizure_led_next;
    logic        non_seizure_led_next;

    // Only a 0->1 transition of result_valid counts as a new result.
    assign capture = result_valid && !valid_prev;
    assign in_hold = (state == HOLD);

    // The blink timer free-runs in HOLD, reloading every time it expires so
    // that the phase toggles every BLINK_HALF cycles.
    assign blink_reload = capture || (in_hold && blink_zero);

    display_timer #(.WIDTH(HOLD_W)) u_hold_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (capture),
        .load_value (HOLD_LOAD),
        .enable     (in_hold),
        .zero       (hold_zero)
    );

    display_timer #(.WIDTH(BLINK_W)) u_blink_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (blink_reload),
        .load_value (BLINK_LOAD),
        .enable     (in_hold),
        .zero       (blink_zero)
    );

    // Next-state and next-output logic. LED outputs are computed from the
    // next state so they can be registered without adding a cycle of delay
    // relative to the capture.
    always_comb begin
        state_next           = state;
        decision_next        = decision;
        conf_next            = conf_latched;
        phase_next           = phase;
        seizure_led_next     = 1'b0;
        non_seizure_led_next = 1'b0;

        case (state)
            IDLE: begin
                if (capture) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (capture) begin
                    state_next = HOLD;
                end else if (hold_zero) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (capture) begin
            decision_next = seizure_detected;
            conf_next     = confidence;
            phase_next    = 1'b1;
        end else if (in_hold && blink_zero) begin
            phase_next = !phase;
        end

        if (state_next == HOLD) begin
            non_seizure_led_next = !decision_next;
            seizure_led_next     = decision_next &&
                                   ((conf_next >= CONF_THRESH) || phase_next);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            valid_prev      <= 1'b0;
            decision        <= 1'b0;
            conf_latched    <= '0;
            phase           <= 1'b0;
            seizure_led     <= 1'b0;
            non_seizure_led <= 1'b0;
            display_busy    <= 1'b0;
            processing_led  <= 1'b0;
        end else begin
            state           <= state_next;
            valid_prev      <= result_valid;
            decision        <= decision_next;
            conf_latched    <= conf_next;
            phase           <= phase_next;
            seizure_led     <= seizure_led_next;
            non_seizure_led <= non_seizure_led_next;
            display_busy    <= (state_next == HOLD);
            processing_led  <= (system_status == STATUS_PROCESSING);
        end
    end

    assign last_confidence = conf_latched;

    // Statistics counters. A clear coincident with a capture leaves the
    // counters holding just that capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            total_count   <= '0;
            seizure_count <= '0;
        end else if (clear_stats) begin
            total_count   <= capture ? COUNT_WIDTH'(1) : '0;
            seizure_count <= (capture && seizure_detected) ? COUNT_WIDTH'(1) : '0;
        end else if (capture) begin
            if (total_count != '1) begin
                total_count <= total_count + 1'b1;
            end
            if (seizure_detected && (seizure_count != '1)) begin
                seizure_count <= seizure_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_result_display_ctrl.sv
// tb_result_display_ctrl
// Scoreboard bench for result_display_ctrl with HOLD_CYCLES=20, BLINK_HALF=4.
// Each stimulus cycle pushes the expected post-edge outputs into a queue;
// a monitor pops one entry per cycle shortly after the rising edge and
// compares only the output groups that entry enables.
module tb_result_display_ctrl;

    localparam int HOLD  = 20;
    localparam int BLINK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        result_valid;
    logic        seizure_detected;
    logic [15:0] confidence;
    logic [1:0]  system_status;
    logic        clear_stats;
    logic        seizure_led;
    logic        non_seizure_led;
    logic        processing_led;
    logic        display_busy;
    logic [7:0]  seizure_count;
    logic [7:0]  total_count;
    logic [15:0] last_confidence;

    always #5 clk = ~clk;

    result_display_ctrl #(
        .HOLD_CYCLES (HOLD),
        .BLINK_HALF  (BLINK),
        .CONF_THRESH (16'h8000),
        .COUNT_WIDTH (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .result_valid     (result_valid),
        .seizure_detected (seizure_detected),
        .confidence       (confidence),
        .system_status    (system_status),
        .clear_stats      (clear_stats),
        .seizure_led      (seizure_led),
        .non_seizure_led  (non_seizure_led),
        .processing_led   (processing_led),
        .display_busy     (display_busy),
        .seizure_count    (seizure_count),
        .total_count      (total_count),
        .last_confidence  (last_confidence)
    );

    typedef struct {
        string       tag;
        bit          chk_led;
        logic        exp_s;
        logic        exp_n;
        logic        exp_b;
        bit          chk_cnt;
        logic [7:0]  exp_sc;
        logic [7:0]  exp_tc;
        bit          chk_conf;
        logic [15:0] exp_conf;
        bit          chk_proc;
        logic        exp_p;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t e_none();
        exp_t e;
        e.tag      = "";
        e.chk_led  = 1'b0;
        e.exp_s    = 1'b0;
        e.exp_n    = 1'b0;
        e.exp_b    = 1'b0;
        e.chk_cnt  = 1'b0;
        e.exp_sc   = 8'h00;
        e.exp_tc   = 8'h00;
        e.chk_conf = 1'b0;
        e.exp_conf = 16'h0000;
        e.chk_proc = 1'b0;
        e.exp_p    = 1'b0;
        return e;
    endfunction

    function automatic exp_t e_led(input string tag, input logic s, input logic n, input logic b);
        exp_t e = e_none();
        e.tag     = tag;
        e.chk_led = 1'b1;
        e.exp_s   = s;
        e.exp_n   = n;
        e.exp_b   = b;
        return e;
    endfunction

    function automatic exp_t add_cnt(input exp_t ein, input logic [7:0] sc, input logic [7:0] tc);
        exp_t e = ein;
        e.chk_cnt = 1'b1;
        e.exp_sc  = sc;
        e.exp_tc  = tc;
        return e;
    endfunction

    function automatic exp_t add_conf(input exp_t ein, input logic [15:0] c);
        exp_t e = ein;
        e.chk_conf = 1'b1;
        e.exp_conf = c;
        return e;
    endfunction

    function automatic exp_t add_proc(input exp_t ein, input logic p);
        exp_t e = ein;
        e.chk_proc = 1'b1;
        e.exp_p    = p;
        return e;
    endfunction

    function automatic exp_t e_cnt(input string tag, input logic [7:0] sc, input logic [7:0] tc);
        exp_t e = e_none();
        e.tag = tag;
        return add_cnt(e, sc, tc);
    endfunction

    function automatic exp_t e_zero(input string tag);
        return add_proc(add_conf(add_cnt(e_led(tag, 1'b0, 1'b0, 1'b0), 8'h00, 8'h00), 16'h0000), 1'b0);
    endfunction

    function automatic logic [7:0] sat8(input int n);
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    // Drive one cycle of inputs at the falling edge and queue the outputs
    // expected after the following rising edge.
    task automatic applyStimulus(input logic rv, input logic sd, input logic [15:0] conf,
                                 input logic [1:0] st, input logic clr, input logic rs,
                                 input exp_t e);
        @(negedge clk);
        result_valid     = rv;
        seizure_detected = sd;
        confidence       = conf;
        system_status    = st;
        clear_stats      = clr;
        rst              = rs;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic rv, input logic sd, input logic [15:0] conf, input exp_t e);
        applyStimulus(rv, sd, conf, 2'b00, 1'b0, 1'b0, e);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, e_zero("reset"));
    endtask

    task automatic checkOutput(input exp_t e);
        if (e.chk_led) begin
            checks++;
            if ({seizure_led, non_seizure_led, display_busy} !== {e.exp_s, e.exp_n, e.exp_b}) begin
                errors++;
                $display("[TB] FAIL %s leds: got seizure=%0b non_seizure=%0b busy=%0b, expected %0b %0b %0b",
                         e.tag, seizure_led, non_seizure_led, display_busy, e.exp_s, e.exp_n, e.exp_b);
            end
        end
        if (e.chk_cnt) begin
            checks++;
            if ({seizure_count, total_count} !== {e.exp_sc, e.exp_tc}) begin
                errors++;
                $display("[TB] FAIL %s counts: got seizure=%0d total=%0d, expected %0d %0d",
                         e.tag, seizure_count, total_count, e.exp_sc, e.exp_tc);
            end
        end
        if (e.chk_conf) begin
            checks++;
            if (last_confidence !== e.exp_conf) begin
                errors++;
                $display("[TB] FAIL %s last_confidence: got %h, expected %h",
                         e.tag, last_confidence, e.exp_conf);
            end
        end
        if (e.chk_proc) begin
            checks++;
            if (processing_led !== e.exp_p) begin
                errors++;
                $display("[TB] FAIL %s processing_led: got %0b, expected %0b",
                         e.tag, processing_led, e.exp_p);
            end
        end
    endtask

    // Monitor: one queue entry per cycle, sampled just after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                checkOutput(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst              = 1'b1;
        result_valid     = 1'b0;
        seizure_detected = 1'b0;
        confidence       = 16'h0000;
        system_status    = 2'b00;
        clear_stats      = 1'b0;

        // Reset with result_valid held high, then one capture after release.
        applyStimulus(1'b1, 1'b0, 16'h1234, 2'b00, 1'b0, 1'b1, e_zero("rst_valid_high"));
        applyStimulus(1'b1, 1'b0, 16'h1234, 2'b00, 1'b0, 1'b1, e_zero("rst_valid_high"));
        cyc(1'b1, 1'b0, 16'h1234,
            add_conf(add_cnt(e_led("post_rst_capture", 1'b0, 1'b1, 1'b1), 8'd0, 8'd1), 16'h1234));
        for (int j = 0; j < 3; j++) begin
            cyc(1'b1, 1'b0, 16'h1234, add_cnt(e_led("held_valid_once", 1'b0, 1'b1, 1'b1), 8'd0, 8'd1));
        end
        doReset();

        // Steady high-confidence seizure for 20 cycles, then a capture exactly
        // when the hold timer hits zero (confidence equal to threshold).
        cyc(1'b0, 1'b0, 16'h0000, e_none());
        cyc(1'b1, 1'b1, 16'hC000,
            add_conf(add_cnt(e_led("steady_hi", 1'b1, 1'b0, 1'b1), 8'd1, 8'd1), 16'hC000));
        for (int j = 1; j < HOLD; j++) begin
            cyc(1'b0, 1'b0, 16'h0000, add_cnt(e_led("steady_hi", 1'b1, 1'b0, 1'b1), 8'd1, 8'd1));
        end
        cyc(1'b1, 1'b1, 16'h8000,
            add_conf(add_cnt(e_led("reload_at_zero", 1'b1, 1'b0, 1'b1), 8'd2, 8'd2), 16'h8000));
        for (int j = 1; j < HOLD; j++) begin
            cyc(1'b0, 1'b0, 16'h0000, e_led("thresh_equal_steady", 1'b1, 1'b0, 1'b1));
        end
        cyc(1'b0, 1'b0, 16'h0000, add_cnt(e_led("hold_end", 1'b0, 1'b0, 1'b0), 8'd2, 8'd2));
        doReset();

        // Low-confidence seizure: 4 on / 4 off / 4 on / 4 off / 4 on, then off.
        cyc(1'b1, 1'b1, 16'h1000,
            add_conf(add_cnt(e_led("blink", 1'b1, 1'b0, 1'b1), 8'd1, 8'd1), 16'h1000));
        for (int j = 1; j < HOLD; j++) begin
            cyc(1'b0, 1'b0, 16'h0000, e_led("blink", ((j / BLINK) % 2) == 0, 1'b0, 1'b1));
        end
        cyc(1'b0, 1'b0, 16'h0000, e_led("blink_end", 1'b0, 1'b0, 1'b0));
        doReset();

        // Non-seizure capture (valid held 5 cycles), restarted at cycle 10 by
        // a seizure capture.
        for (int j = 0; j < 5; j++) begin
            cyc(1'b1, 1'b0, 16'h0100, add_cnt(e_led("non_seizure", 1'b0, 1'b1, 1'b1), 8'd0, 8'd1));
        end
        for (int j = 5; j < 10; j++) begin
            cyc(1'b0, 1'b0, 16'h0000, add_cnt(e_led("non_seizure", 1'b0, 1'b1, 1'b1), 8'd0, 8'd1));
        end
        cyc(1'b1, 1'b1, 16'hFFFF,
            add_conf(add_cnt(e_led("restart_seizure", 1'b1, 1'b0, 1'b1), 8'd1, 8'd2), 16'hFFFF));
        for (int j = 11; j < 30; j++) begin
            cyc(1'b0, 1'b0, 16'h0000, add_cnt(e_led("restart_seizure", 1'b1, 1'b0, 1'b1), 8'd1, 8'd2));
        end
        cyc(1'b0, 1'b0, 16'h0000, e_led("restart_end", 1'b0, 1'b0, 1'b0));
        doReset();

        // 300 seizure captures: counters saturate at 255.
        for (int i = 1; i <= 300; i++) begin
            cyc(1'b1, 1'b1, 16'(i), e_cnt("saturate", sat8(i), sat8(i)));
            cyc(1'b0, 1'b0, 16'h0000, e_none());
        end
        applyStimulus(1'b1, 1'b1, 16'h4000, 2'b00, 1'b1, 1'b0, e_cnt("clear_with_capture", 8'd1, 8'd1));
        cyc(1'b0, 1'b0, 16'h0000, e_cnt("after_clear", 8'd1, 8'd1));
        applyStimulus(1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, e_cnt("clear_only", 8'd0, 8'd0));
        doReset();

        // processing_led follows system_status.
        applyStimulus(1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, add_proc(e_none(), 1'b0));
        applyStimulus(1'b0, 1'b0, 16'h0000, 2'b01, 1'b0, 1'b0, add_proc(e_led("status_01", 1'b0, 1'b0, 1'b0), 1'b1));
        applyStimulus(1'b0, 1'b0, 16'h0000, 2'b10, 1'b0, 1'b0, add_proc(e_led("status_10", 1'b0, 1'b0, 1'b0), 1'b0));
        applyStimulus(1'b0, 1'b0, 16'h0000, 2'b11, 1'b0, 1'b0, add_proc(e_led("status_11", 1'b0, 1'b0, 1'b0), 1'b0));

        // Reset mid-HOLD with valid still high: zeros, then a fresh capture.
        cyc(1'b1, 1'b1, 16'hC000, e_led("pre_rst_hold", 1'b1, 1'b0, 1'b1));
        cyc(1'b1, 1'b1, 16'hC000, e_led("pre_rst_hold", 1'b1, 1'b0, 1'b1));
        applyStimulus(1'b1, 1'b1, 16'hC000, 2'b00, 1'b0, 1'b1, e_zero("rst_mid_hold"));
        cyc(1'b1, 1'b1, 16'hC000,
            add_conf(add_cnt(e_led("fresh_after_rst", 1'b1, 1'b0, 1'b1), 8'd1, 8'd1), 16'hC000));
        cyc(1'b0, 1'b0, 16'h0000, add_cnt(e_led("fresh_after_rst", 1'b1, 1'b0, 1'b1), 8'd1, 8'd1));

        cyc(1'b0, 1'b0, 16'h0000, e_none());
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
